// File: rtl/hd_secded_decoder.sv
// -----------------------------------------------------------------------------
// hd_secded_decoder
//
// Two-stage pipelined Hamming SEC-DED decoder. This is the receive-side partner
// of the Hamming encoder. It takes one N-bit codeword per cycle and returns the
// K-bit data word. It corrects single-bit errors and flags double-bit errors.
// Two saturating counters record how many corrected and how many uncorrectable
// words have been seen.
//
// Codeword layout (N = K+R+1):
//   din[0]           overall even parity over all N bits
//   din[p], p=1..K+R Hamming position p
//   check bit j sits at position 2**j and covers every position with bit j set
//   data bits fill the non-power-of-2 positions in ascending order
//   (data[0] is at position 3)
//
// Handshake: dvld is sampled on every rising edge and there is no backpressure.
// A word sampled with dvld=1 at edge t is presented with qvld=1 from edge t+1,
// so it is observed at edge t+2. When qvld=0, qout, err_corr and err_uncorr are
// all 0.
//
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous, active-low reset
//   din         in   N      received codeword
//   dvld        in   1      din valid
//   clr_cnt     in   1      synchronous clear of both counters (wins over +1)
//   qout        out  K      decoded (corrected) data
//   qvld        out  1      qout valid
//   err_corr    out  1      single error corrected in this word
//   err_uncorr  out  1      uncorrectable error in this word
//   corr_cnt    out  CNT_W  saturating count of qvld&err_corr cycles
//   uncorr_cnt  out  CNT_W  saturating count of qvld&err_uncorr cycles
//
// K+R must not exceed 2**R-1. Otherwise a syndrome cannot address every
// codeword position.
// -----------------------------------------------------------------------------
module hd_secded_decoder #(
  parameter int K     = 8,
  parameter int R     = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [K+R:0]     din,
  input  logic             dvld,
  input  logic             clr_cnt,
  output logic [K-1:0]     qout,
  output logic             qvld,
  output logic             err_corr,
  output logic             err_uncorr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam int N = K + R + 1;
  localparam int M = K + R;  // highest Hamming position

  // Highest position a syndrome may legally point at.
  localparam logic [R-1:0] MAX_POS = R'(M);

  // Set of codeword positions covered by check bit j.
  function automatic logic [N-1:0] cover_mask(input int j);
    logic [N-1:0] m;
    m = '0;
    for (int p = 1; p <= M; p++) begin
      if (((p >> j) & 1) == 1) m[p] = 1'b1;
    end
    return m;
  endfunction

  // Codeword position of data bit idx. Data bits occupy the positions that
  // are not powers of two, in ascending order.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p <= M; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: syndrome, overall parity and raw data.
  // ---------------------------------------------------------------------------
  logic [R-1:0] w_syn;
  logic         w_par;
  logic [K-1:0] w_raw_data;

  // Syndrome bit j is the parity of every position covered by check bit j.
  // This equals bit j of the XOR of the indices of all set positions.
  // din[0] is never covered because position 0 has no bit set.
  for (genvar j = 0; j < R; j++) begin : g_syn
    assign w_syn[j] = ^(din & cover_mask(j));
  end

  assign w_par = ^din;

  for (genvar i = 0; i < K; i++) begin : g_raw
    assign w_raw_data[i] = din[data_pos(i)];
  end

  // Only the data positions are carried forward. Check-bit positions hold no
  // payload, and a flip in one of them never changes the data. Each field is
  // zeroed on invalid cycles so no stale data runs down the pipe.
  logic         r1_vld;
  logic [R-1:0] r1_syn;
  logic         r1_par;
  logic [K-1:0] r1_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_vld  <= 1'b0;
      r1_syn  <= '0;
      r1_par  <= 1'b0;
      r1_data <= '0;
    end else begin
      r1_vld  <= dvld;
      r1_syn  <= dvld ? w_syn      : '0;
      r1_par  <= dvld ? w_par      : 1'b0;
      r1_data <= dvld ? w_raw_data : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: decode table and correction.
  //   s==0, P==0          clean
  //   s==0, P==1          parity bit itself flipped; data untouched, corrected
  //   s!=0, P==1, s<=K+R  single error at position s; flip it, corrected
  //   s!=0, P==1, s>K+R   points outside the codeword; uncorrectable
  //   s!=0, P==0          double error; uncorrectable
  // ---------------------------------------------------------------------------
  logic         w_s_zero;
  logic         w_in_range;
  logic         w_flip_en;
  logic         w_corr;
  logic         w_uncorr;
  logic [K-1:0] w_data;

  assign w_s_zero   = (r1_syn == '0);
  assign w_in_range = (r1_syn <= MAX_POS);
  assign w_flip_en  = r1_par & ~w_s_zero & w_in_range;
  assign w_corr     = r1_par & (w_s_zero | w_in_range);
  assign w_uncorr   = ~w_s_zero & ~(r1_par & w_in_range);

  // A data bit flips only when the syndrome names its own position.
  for (genvar i = 0; i < K; i++) begin : g_fix
    localparam logic [R-1:0] POS = R'(data_pos(i));
    assign w_data[i] = r1_data[i] ^ (w_flip_en & (r1_syn == POS));
  end

  logic         r_qvld;
  logic [K-1:0] r_qout;
  logic         r_err_corr;
  logic         r_err_uncorr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_qvld       <= 1'b0;
      r_qout       <= '0;
      r_err_corr   <= 1'b0;
      r_err_uncorr <= 1'b0;
    end else begin
      r_qvld       <= r1_vld;
      r_qout       <= r1_vld ? w_data : '0;
      r_err_corr   <= r1_vld & w_corr;
      r_err_uncorr <= r1_vld & w_uncorr;
    end
  end

  // ---------------------------------------------------------------------------
  // Event counters. Each one counts the flags currently on the outputs, so it
  // updates one edge after the word it counts. Clear takes priority, and each
  // counter stops at all-ones.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (clr_cnt) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (r_qvld && r_err_corr && (r_corr_cnt != '1))
        r_corr_cnt <= r_corr_cnt + 1'b1;
      if (r_qvld && r_err_uncorr && (r_uncorr_cnt != '1))
        r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
    end
  end

  assign qout       = r_qout;
  assign qvld       = r_qvld;
  assign err_corr   = r_err_corr;
  assign err_uncorr = r_err_uncorr;
  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;

endmodule

// File: tb/tb_hd_secded_decoder.sv
// -----------------------------------------------------------------------------
// tb_hd_secded_decoder
//
// Drives two decoder instances with the same inputs. dut_a uses 16-bit
// counters and dut_b uses 2-bit counters. The expected values come from a
// behavioural encoder/error-injection model: the bench knows how many bits it
// flipped in each word, which gives the expected data, flags and counts.
// -----------------------------------------------------------------------------
module tb_hd_secded_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [12:0] din = '0;
  logic        dvld = 1'b0;
  logic        clr_cnt = 1'b0;

  logic [7:0]  qout_a, qout_b;
  logic        qvld_a, qvld_b;
  logic        ec_a, ec_b, eu_a, eu_b;
  logic [15:0] cc_a, uc_a;
  logic [1:0]  cc_b, uc_b;

  hd_secded_decoder #(.K(8), .R(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .din(din), .dvld(dvld), .clr_cnt(clr_cnt),
    .qout(qout_a), .qvld(qvld_a), .err_corr(ec_a), .err_uncorr(eu_a),
    .corr_cnt(cc_a), .uncorr_cnt(uc_a)
  );

  hd_secded_decoder #(.K(8), .R(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .din(din), .dvld(dvld), .clr_cnt(clr_cnt),
    .qout(qout_b), .qvld(qvld_b), .err_corr(ec_b), .err_uncorr(eu_b),
    .corr_cnt(cc_b), .uncorr_cnt(uc_b)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_pass  = 0;
  int n_total = 0;
  // Each entry is {vld, corr, uncorr, data[7:0]}.
  logic [10:0] exp_q[$];
  int   m_cc_a = 0, m_uc_a = 0, m_cc_b = 0, m_uc_b = 0;
  logic pend_c = 1'b0, pend_u = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] cw;
    int k;
    logic par;
    cw = '0;
    k  = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 12; p++)
        if (((p >> j) & 1) == 1) par ^= cw[p];
      cw[1 << j] = par;
    end
    cw[0] = ^cw[12:1];
    return cw;
  endfunction

  function automatic logic [7:0] extract(input logic [12:0] cw);
    logic [7:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = cw[p];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [10:0] make_exp(input logic v, input logic [7:0] d,
                                           input logic [12:0] bad, input int nflip);
    if (!v) return 11'h000;
    if (nflip == 0) return {3'b100, d};
    if (nflip == 1) return {3'b110, d};
    return {3'b101, extract(bad)};
  endfunction

  // ---------------- driver ----------------
  // Presents one input cycle, then checks the outputs half a cycle after the
  // edge. The counter model adds the flags that were on the outputs during
  // this edge.
  task automatic cycle(input logic [12:0] cw, input logic v, input logic c,
                       input logic [10:0] e);
    logic [10:0] o;
    din = cw;
    dvld = v;
    clr_cnt = c;
    exp_q.push_back(e);
    if (c) begin
      m_cc_a = 0; m_uc_a = 0; m_cc_b = 0; m_uc_b = 0;
    end else begin
      if (pend_c) begin
        if (m_cc_a < 65535) m_cc_a++;
        if (m_cc_b < 3) m_cc_b++;
      end
      if (pend_u) begin
        if (m_uc_a < 65535) m_uc_a++;
        if (m_uc_b < 3) m_uc_b++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    o = exp_q.pop_front();
    check("qvld",       qvld_a, o[10]);
    check("qout",       qout_a, o[7:0]);
    check("err_corr",   ec_a,   o[9]);
    check("err_uncorr", eu_a,   o[8]);
    check("qvld_b",     qvld_b, o[10]);
    check("corr_cnt",   cc_a,   m_cc_a);
    check("uncorr_cnt", uc_a,   m_uc_a);
    check("corr_cnt_b", cc_b,   m_cc_b);
    check("uncorr_cnt_b", uc_b, m_uc_b);
    pend_c = o[10] & o[9];
    pend_u = o[10] & o[8];
  endtask

  task automatic send(input logic v, input logic [7:0] d, input int nflip, input logic c);
    logic [12:0] bad;
    int p1, p2;
    bad = encode(d);
    p1 = $urandom_range(0, 12);
    p2 = (p1 + $urandom_range(1, 12)) % 13;
    if (nflip >= 1) bad[p1] = ~bad[p1];
    if (nflip >= 2) bad[p2] = ~bad[p2];
    cycle(bad, v, c, make_exp(v, d, bad, nflip));
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(11'h000);
    m_cc_a = 0; m_uc_a = 0; m_cc_b = 0; m_uc_b = 0;
    pend_c = 1'b0; pend_u = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Outputs must be zero while reset is held.
    #1;
    check("rst_qvld", qvld_a, 1'b0);
    check("rst_qout", qout_a, 8'h00);
    check("rst_cnt",  cc_a,   16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Directed vectors.
    cycle(13'h000F, 1'b1, 1'b0, 11'h401);              // clean, data 0x01
    cycle(13'h002F, 1'b1, 1'b0, 11'h601);              // bit 5 flipped
    cycle(13'h000E, 1'b1, 1'b0, 11'h601);              // parity bit flipped
    cycle(13'h006F, 1'b1, 1'b0, make_exp(1'b1, 8'h01, 13'h006F, 2)); // double
    cycle(13'h0112, 1'b1, 1'b0, 11'h500);              // syndrome 13 > K+R
    repeat (3) cycle(13'h0000, 1'b0, 1'b0, 11'h000);

    // Random words with 0 or 1 flipped bit and a toggling valid.
    for (int i = 0; i < 100; i++)
      send(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 1), 1'b0);
    // A few double errors.
    for (int i = 0; i < 4; i++)
      send(1'b1, 8'($urandom), 2, 1'b0);

    // Saturation of the 2-bit counters, then a clear that lands together with
    // a pending increment.
    for (int i = 0; i < 5; i++)
      send(1'b1, 8'($urandom), 1, 1'b0);
    send(1'b1, 8'($urandom), 1, 1'b1);
    send(1'b1, 8'($urandom), 1, 1'b0);
    send(1'b1, 8'($urandom), 2, 1'b0);
    repeat (2) cycle(13'h0000, 1'b0, 1'b0, 11'h000);

    // Reset with words in flight.
    send(1'b1, 8'hA5, 1, 1'b0);
    send(1'b1, 8'h3C, 0, 1'b0);
    rst = 1'b0;
    #1;
    check("arst_qvld", qvld_a, 1'b0);
    check("arst_qout", qout_a, 8'h00);
    check("arst_corr", ec_a,   1'b0);
    check("arst_unc",  eu_a,   1'b0);
    check("arst_cc",   cc_a,   16'h0000);
    check("arst_uc",   uc_a,   16'h0000);
    din = encode(8'h77);
    dvld = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_qvld", qvld_a, 1'b0);
      check("hold_qout", qout_a, 8'h00);
    end
    rst = 1'b1;
    model_reset();
    repeat (4) cycle(13'h0000, 1'b0, 1'b0, 11'h000);
    send(1'b1, 8'h5A, 1, 1'b0);
    repeat (3) cycle(13'h0000, 1'b0, 1'b0, 11'h000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
